// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the existing receiver.
//   tx_state_t    : transmitter FSM state encoding
//   DEF_CLK_FREQ  : default system clock frequency in Hz
//   DEF_BAUD      : default line rate in bit/s
//   bit_cycles()  : clocks per bit for a given clock frequency and line rate
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 9600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Integer division; the residual baud error is accepted (0.006% at defaults).
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO used as the transmit queue.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous reset, active-high (pointers and count only)
//   push_i   : write wdata_i when not full
//   wdata_i  : byte to write
//   pop_i    : advance read pointer when not empty
//   rdata_o  : byte at the head of the queue (valid when not empty)
//   full_o   : count == DEPTH
//   empty_o  : count == 0
//   count_o  : number of stored bytes
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [7:0]                 wdata_i,
  input  logic                       pop_i,
  output logic [7:0]                 rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard here too so the FIFO stays consistent whatever the caller does.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap modulo DEPTH (a power of two); the count tells full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; stale entries are unreachable once the count is zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte queue.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-high
//   tx_data    : byte to send
//   tx_valid   : tx_data valid; accepted when tx_ready is high at a rising edge
//   tx_ready   : queue can accept a byte (not full)
//   UART_TX    : serial line, idle high, LSB first, one start and one stop bit
//   busy       : frame in progress or queue non-empty
//   fifo_count : queued bytes, excluding the byte currently being shifted
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          UART_TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned BW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BitLast  = BW'(BIT_CYCLES - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_rdata;
  logic          bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Derived from the registered count only, so no path from tx_valid.
  assign tx_ready = ~fifo_full;
  assign UART_TX  = tx_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;
  assign bit_end  = (baud_q == BitLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    // Free-running bit timer while a frame is active; wraps at each bit boundary.
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BW'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // The next bit is shift_q[1]; present it as the register shifts.
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle gap.
            pop     = 1'b1;
            shift_d = fifo_rdata;
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int unsigned BC = 10;  // clocks per bit for the small instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Small instance: CLK_FREQ=1000, BAUD=100 -> 10 clocks per bit.
  logic       rst, tx_valid, tx_ready, line, busy;
  logic [7:0] tx_data;
  logic [2:0] cnt;

  // Default-parameter instance.
  logic       rst_d, valid_d, ready_d, line_d, busy_d;
  logic [7:0] data_d;
  logic [2:0] cnt_d;

  uart_tx #(
    .CLK_FREQ   (1000),
    .BAUD       (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .UART_TX    (line),
    .busy       (busy),
    .fifo_count (cnt)
  );

  uart_tx dut_def (
    .clk        (clk),
    .rst        (rst_d),
    .tx_data    (data_d),
    .tx_valid   (valid_d),
    .tx_ready   (ready_d),
    .UART_TX    (line_d),
    .busy       (busy_d),
    .fifo_count (cnt_d)
  );

  typedef struct {
    int unsigned cyc;
    logic        tx;
    logic        busy;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_low(input int limit, output int unsigned s);
    s = 0;
    for (int i = 0; i < limit; i++) begin
      if (line === 1'b0) begin
        s = cyc;
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("FAIL start bit timeout: got line high for %0d cycles expected a start bit", limit);
  endtask

  // Mid-bit sampling receiver for a frame whose start bit first appears at cycle s.
  task automatic rx_body(input int unsigned s, output logic [7:0] b);
    while (cyc < s + 5) step();
    check("start bit mid", {31'd0, line}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      while (cyc < s + 15 + 10 * i) step();
      b[i] = line;
    end
    while (cyc < s + 95) step();
    check("stop bit mid", {31'd0, line}, 32'd1);
  endtask

  task automatic rx_next(input string name, input logic [7:0] exp, output int unsigned s);
    logic [7:0] b;
    wait_low(400, s);
    rx_body(s, b);
    check(name, {24'd0, b}, {24'd0, exp});
  endtask

  initial begin
    int unsigned c0, s1, s2, s3;
    logic [7:0]  b;
    bit          saw_low;

    vecs[0]  = '{0,   1'b1, 1'b1, 3'd1};
    vecs[1]  = '{1,   1'b0, 1'b1, 3'd0};
    vecs[2]  = '{10,  1'b0, 1'b1, 3'd0};
    vecs[3]  = '{11,  1'b1, 1'b1, 3'd0};
    vecs[4]  = '{20,  1'b1, 1'b1, 3'd0};
    vecs[5]  = '{21,  1'b0, 1'b1, 3'd0};
    vecs[6]  = '{31,  1'b1, 1'b1, 3'd0};
    vecs[7]  = '{41,  1'b0, 1'b1, 3'd0};
    vecs[8]  = '{51,  1'b0, 1'b1, 3'd0};
    vecs[9]  = '{61,  1'b1, 1'b1, 3'd0};
    vecs[10] = '{71,  1'b0, 1'b1, 3'd0};
    vecs[11] = '{80,  1'b0, 1'b1, 3'd0};
    vecs[12] = '{81,  1'b1, 1'b1, 3'd0};
    vecs[13] = '{90,  1'b1, 1'b1, 3'd0};
    vecs[14] = '{91,  1'b1, 1'b1, 3'd0};
    vecs[15] = '{100, 1'b1, 1'b1, 3'd0};
    vecs[16] = '{101, 1'b1, 1'b0, 3'd0};

    rst = 1'b1;  tx_valid = 1'b0; tx_data = 8'h00;
    rst_d = 1'b1; valid_d = 1'b0; data_d = 8'h00;
    step(3);
    check("reset line",     {31'd0, line},     32'd1);
    check("reset ready",    {31'd0, tx_ready}, 32'd1);
    check("reset busy",     {31'd0, busy},     32'd0);
    check("reset count",    {29'd0, cnt},      32'd0);
    check("reset def line", {31'd0, line_d},   32'd1);
    check("reset def busy", {31'd0, busy_d},   32'd0);
    rst = 1'b0;
    rst_d = 1'b0;
    step(3);

    // Single byte 0xA5 against the timing table.
    tx_data = 8'hA5; tx_valid = 1'b1;
    step();
    c0 = cyc;
    tx_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      while (cyc - c0 < vecs[i].cyc) step();
      check($sformatf("vec%0d line", i),  {31'd0, line}, {31'd0, vecs[i].tx});
      check($sformatf("vec%0d busy", i),  {31'd0, busy}, {31'd0, vecs[i].busy});
      check($sformatf("vec%0d count", i), {29'd0, cnt},  {29'd0, vecs[i].cnt});
    end
    step(5);

    // Back-to-back 0x00, 0xFF, 0x55.
    tx_valid = 1'b1; tx_data = 8'h00;
    step();
    c0 = cyc;
    tx_data = 8'hFF;
    step();
    check("b2b first start", {31'd0, line}, 32'd0);
    check("b2b count after push/pop", {29'd0, cnt}, 32'd1);
    tx_data = 8'h55;
    step();
    tx_valid = 1'b0;
    s1 = c0 + 1;
    rx_body(s1, b);
    check("b2b byte0", {24'd0, b}, 32'h00);
    rx_next("b2b byte1", 8'hFF, s2);
    check("b2b gap 1", s2 - s1, 32'd100);
    rx_next("b2b byte2", 8'h55, s3);
    check("b2b gap 2", s3 - s2, 32'd100);
    step(5);
    check("b2b end busy", {31'd0, busy}, 32'd0);
    check("b2b end line", {31'd0, line}, 32'd1);
    step(5);

    // Full FIFO: 0x10..0x15 one per cycle, 0x15 dropped.
    c0 = 0;
    for (int k = 0; k < 6; k++) begin
      tx_data = 8'h10 + 8'(k);
      tx_valid = 1'b1;
      step();
      if (k == 0) c0 = cyc;
      if (k == 4) begin
        check("full ready", {31'd0, tx_ready}, 32'd0);
        check("full count", {29'd0, cnt},      32'd4);
      end
    end
    tx_valid = 1'b0;
    check("full count after drop", {29'd0, cnt}, 32'd4);
    rx_body(c0 + 1, b);
    check("full byte 0x10", {24'd0, b}, 32'h10);
    for (int k = 1; k < 5; k++) begin
      rx_next($sformatf("full byte %0d", k), 8'h10 + 8'(k), s1);
    end
    saw_low = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (line !== 1'b1) saw_low = 1'b1;
    end
    check("full no sixth frame", {31'd0, saw_low}, 32'd0);
    check("full idle busy", {31'd0, busy}, 32'd0);

    // Simultaneous push and pop on the STOP->START edge.
    tx_valid = 1'b1;
    tx_data = 8'hA0; step(); c0 = cyc;
    tx_data = 8'hA1; step();
    tx_data = 8'hA2; step();
    tx_valid = 1'b0;
    s1 = c0 + 1;
    while (cyc < s1 + 99) step();
    check("pp count before", {29'd0, cnt}, 32'd2);
    tx_data = 8'hA3; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("pp count after", {29'd0, cnt}, 32'd2);
    check("pp new start", {31'd0, line}, 32'd0);
    rx_body(s1 + 100, b);
    check("pp byte A1", {24'd0, b}, 32'hA1);
    rx_next("pp byte A2", 8'hA2, s2);
    rx_next("pp byte A3", 8'hA3, s3);
    step(5);
    check("pp idle busy", {31'd0, busy}, 32'd0);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    tx_valid = 1'b1;
    tx_data = 8'h3C; step(); c0 = cyc;
    tx_data = 8'h77; step();
    tx_data = 8'h88; step();
    tx_valid = 1'b0;
    s1 = c0 + 1;
    while (cyc < s1 + 44) step();
    check("rst pre count", {29'd0, cnt}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("rst async line",  {31'd0, line},     32'd1);
    check("rst async count", {29'd0, cnt},      32'd0);
    check("rst async busy",  {31'd0, busy},     32'd0);
    check("rst async ready", {31'd0, tx_ready}, 32'd1);
    step(2);
    rst = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (line !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
    end
    check("rst no resume", {31'd0, saw_low}, 32'd0);

    // Default parameters: 5208 clocks per bit, 0x41.
    data_d = 8'h41; valid_d = 1'b1;
    step();
    c0 = cyc;
    valid_d = 1'b0;
    step();
    check("def start", {31'd0, line_d}, 32'd0);
    s1 = c0 + 1;
    while (line_d === 1'b0 && cyc < s1 + 6000) step();
    check("def start length", cyc - s1, 32'd5208);
    for (int i = 0; i < 8; i++) begin
      while (cyc < s1 + 5208 * (i + 1) + 2604) step();
      b[i] = line_d;
    end
    check("def byte", {24'd0, b}, 32'h41);
    while (cyc < s1 + 9 * 5208 + 2604) step();
    check("def stop", {31'd0, line_d}, 32'd1);
    while (cyc < s1 + 52079) step();
    check("def busy last clock", {31'd0, busy_d}, 32'd1);
    step();
    check("def busy after frame", {31'd0, busy_d}, 32'd0);
    check("def line idle", {31'd0, line_d}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
